epu_in_axi_slave: RTL and testbench
===================================

// Module: epu_in_axi_slave
// PURPOSE
// AXI4 slave front end that drives the EPU input-buffer port (inf_EPUIN initiator side).
// - Accepts AXI read/write bursts from the bus.
// - Converts them into the arhns/awhns/whns/rlast/wrfin/CS/OE/addr/wdata strobes the input-SRAM wrapper consumes.
// - Returns SRAM read data on the R channel.
// - Sits between the EPU AXI slave port and the input-SRAM wrapper.
// PARAMETERS
// ID_W    8   AXI ID width
// ADDR_W  32  AXI address width
// DATA_W  32  data width (word = 4 bytes)
// LEN_W   4   AXLEN width (bursts 1..16 beats)
// PORTS
// clk       in   1       clock
// rstn      in   1       async active-low reset
// enb_i     in   1       buffer access enable from EPU wrapper
// AWID/AWADDR/AWLEN/AWBURST/AWVALID  in   ID_W/ADDR_W/LEN_W/2/1   write address channel
// AWREADY   out  1       write address ready
// WDATA/WSTRB/WLAST/WVALID           in   DATA_W/4/1/1            write data (WSTRB ignored, full-word writes)
// WREADY    out  1       write data ready
// BID/BRESP/BVALID  out  ID_W/2/1  write response; BREADY in 1
// ARID/ARADDR/ARLEN/ARBURST/ARVALID  in   ID_W/ADDR_W/LEN_W/2/1   read address channel
// ARREADY   out  1       read address ready
// RID/RDATA/RRESP/RLAST/RVALID      out  ID_W/DATA_W/2/1/1       read data; RREADY in 1
// arhns     out  1       AR handshake pulse to wrapper
// awhns     out  1       AW handshake pulse to wrapper
// whns      out  1       W beat handshake (wrapper write strobe)
// rlast     out  1       final R handshake pulse (wrapper leaves read state)
// wrfin     out  1       write burst finished (wrapper leaves write state)
// CS        out  1       buffer chip select
// OE        out  1       buffer output enable
// addr      out  ADDR_W  byte address to buffer (wrapper uses [19:2])
// wdata     out  DATA_W  write data to buffer
// rdata_i   in   DATA_W  buffer read data (1-cycle SRAM latency)
// rvalid_i  in   1       wrapper in read state (diagnostic only; RVALID is FSM-driven)
// BEHAVIOUR
// Reset: state IDLE.
// - All ready/valid outputs 0, all strobes 0, addr/wdata 0.
// - Burst counter and address register 0, RID/BID 0.
// FSM states: IDLE, R_DATA, W_DATA, B_RESP.
// IDLE:
// - ARREADY = enb_i; AWREADY = enb_i & ~ARVALID. Read has priority when both are valid.
// - On ARVALID & ARREADY: arhns=1, CS=1, addr=ARADDR (combinational, same cycle).
//   Latch ARID, ARLEN, ARBURST and ARADDR -> R_DATA.
// - On AWVALID & AWREADY: awhns=1; latch AWID, AWLEN, AWBURST and AWADDR -> W_DATA.
// R_DATA:
// - CS=OE=1, RVALID=1, RDATA=rdata_i, RID latched, RRESP=2'b00.
// - RLAST=1 when beat count == len.
// - addr output = next beat address when RVALID & RREADY, else the current beat address.
//   This gives full throughput with 1-cycle SRAM latency; data holds stable under backpressure.
// - Last beat handshake: rlast=1 for that cycle -> IDLE.
// W_DATA:
// - CS=1, OE=0, WREADY=1, addr = current beat address, wdata = WDATA.
// - whns = WVALID & WREADY.
// - Each handshake increments the beat count and advances the address.
// - Handshake with WLAST (or count == len) -> B_RESP.
// B_RESP:
// - wrfin=1, BVALID=1, BID latched, BRESP=2'b00, CS=0.
// - On BREADY -> IDLE.
// Address update:
// - INCR (2'b01) and WRAP/reserved: +4 per beat; wraps modulo 2^ADDR_W with no boundary check.
// - FIXED (2'b00): address held constant.
// Beat count: LEN_W+1 bits; burst length = AxLEN+1.
// WLAST early (before len) ends the burst; WLAST late is ignored (burst ends at len).
// enb_i low: no new AR/AW accepted. Bursts already in progress complete regardless.
// Ready timing: no ARREADY/AWREADY outside IDLE. Exactly one transaction is outstanding at a time.
// Async reset mid-burst: immediately IDLE with all outputs 0. The partial burst is dropped and no B/R is issued.
// TESTING
// 1. AR ARADDR=0x100 ARLEN=3 INCR, RREADY=1
//    -> arhns 1 cycle; addr 0x100,0x104,0x108,0x10C on consecutive cycles.
//    -> 4 RVALID beats; RLAST and rlast on beat 4; then IDLE.
// 2. Same read with RREADY low for 3 cycles at beat 2
//    -> addr held at 0x104, RDATA stable; no skipped or duplicated beat.
// 3. AW 0x200 AWLEN=1 AWID=5, W beats 0xA,0xB with a 2-cycle WVALID gap
//    -> whns only on handshakes; addr 0x200/0x204; wrfin and BVALID; BID=5, BRESP=0.
// 4. ARVALID and AWVALID in the same cycle -> read served first; AWREADY=0 until read done, then write accepted.
// 5. enb_i=0 with ARVALID=1 -> ARREADY stays 0; ARREADY rises in the cycle enb_i returns to 1.
// 6. rstn low during W beat 2 of 4 -> all outputs 0 immediately; a fresh AR after release completes normally.
//    Also: FIXED read ARLEN=2 -> addr constant on all beats.

Source files
------------

// File: rtl/epu_in_axi_slave.sv
// ---------------------------------------------------------------------------
// epu_in_axi_slave
// AXI4 slave front end for the EPU input buffer. It serves one AXI burst at a
// time and turns it into the strobes the input-SRAM wrapper consumes.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   enb_i                buffer access enable (gates acceptance of new AR/AW)
//   AW*/W*/B*            AXI write address / data / response channels
//   AR*/R*               AXI read address / data channels
//   arhns, awhns         address handshake pulses to the wrapper
//   whns                 per-beat write strobe to the wrapper
//   rlast                pulse on the final R handshake
//   wrfin                write burst finished (held while BVALID)
//   CS, OE, addr, wdata  SRAM control, byte address and write data
//   rdata_i              SRAM read data (one cycle after addr)
//   rvalid_i             wrapper read-state flag, diagnostic only
// ---------------------------------------------------------------------------
module epu_in_axi_slave #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enb_i,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              arhns,
  output logic              awhns,
  output logic              whns,
  output logic              rlast,
  output logic              wrfin,
  output logic              CS,
  output logic              OE,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rvalid_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    R_DATA = 2'd1,
    W_DATA = 2'd2,
    B_RESP = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [ID_W-1:0]   id_r;
  logic [LEN_W-1:0]  len_r;
  logic [1:0]        burst_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W:0]    cnt_r;

  logic              enb_s;
  logic              ar_hs_s;
  logic              aw_hs_s;
  logic              last_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic              unused_s;

  // Gating with rstn keeps the combinational readies low while reset is held.
  assign enb_s      = enb_i & rstn;
  assign ar_hs_s    = ARVALID & enb_s;
  assign aw_hs_s    = AWVALID & enb_s & ~ARVALID;
  assign last_s     = (cnt_r == {1'b0, len_r});
  // FIXED holds the address; INCR and everything else step one word, wrapping mod 2^ADDR_W.
  assign addr_nxt_s = (burst_r == 2'b00) ? addr_r : (addr_r + ADDR_W'(4));
  assign RRESP      = 2'b00;
  assign BRESP      = 2'b00;
  assign unused_s   = ^{WSTRB, rvalid_i};

  // State register plus burst context (id, length, type, beat address, beat count).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      id_r    <= {ID_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      burst_r <= 2'b00;
      addr_r  <= {ADDR_W{1'b0}};
      cnt_r   <= {(LEN_W+1){1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (ar_hs_s) begin
            id_r    <= ARID;
            len_r   <= ARLEN;
            burst_r <= ARBURST;
            addr_r  <= ARADDR;
            cnt_r   <= {(LEN_W+1){1'b0}};
          end else if (aw_hs_s) begin
            id_r    <= AWID;
            len_r   <= AWLEN;
            burst_r <= AWBURST;
            addr_r  <= AWADDR;
            cnt_r   <= {(LEN_W+1){1'b0}};
          end
        end
        R_DATA: begin
          if (RREADY) begin
            cnt_r  <= cnt_r + {{LEN_W{1'b0}}, 1'b1};
            addr_r <= addr_nxt_s;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            cnt_r  <= cnt_r + {{LEN_W{1'b0}}, 1'b1};
            addr_r <= addr_nxt_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Next-state and all channel/strobe outputs, decoded from the current state.
  always_comb begin
    state_s = state_r;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BID     = {ID_W{1'b0}};
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    RID     = {ID_W{1'b0}};
    RDATA   = {DATA_W{1'b0}};
    arhns   = 1'b0;
    awhns   = 1'b0;
    whns    = 1'b0;
    rlast   = 1'b0;
    wrfin   = 1'b0;
    CS      = 1'b0;
    OE      = 1'b0;
    addr    = {ADDR_W{1'b0}};
    wdata   = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        ARREADY = enb_s;
        AWREADY = enb_s & ~ARVALID;
        if (ar_hs_s) begin
          // Present the first address now so beat 0 data is ready next cycle.
          arhns   = 1'b1;
          CS      = 1'b1;
          addr    = ARADDR;
          state_s = R_DATA;
        end else if (aw_hs_s) begin
          awhns   = 1'b1;
          state_s = W_DATA;
        end else begin
          state_s = IDLE;
        end
      end
      R_DATA: begin
        CS     = 1'b1;
        OE     = 1'b1;
        RVALID = 1'b1;
        RDATA  = rdata_i;
        RID    = id_r;
        RLAST  = last_s;
        if (RREADY) begin
          // Prefetch the next beat; under backpressure re-present the current one.
          addr = addr_nxt_s;
          if (last_s) begin
            rlast   = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = R_DATA;
          end
        end else begin
          addr    = addr_r;
          state_s = R_DATA;
        end
      end
      W_DATA: begin
        CS     = 1'b1;
        WREADY = 1'b1;
        addr   = addr_r;
        wdata  = WDATA;
        whns   = WVALID;
        // Early WLAST ends the burst; a late WLAST is covered by the count.
        if (WVALID && (WLAST || last_s)) begin
          state_s = B_RESP;
        end else begin
          state_s = W_DATA;
        end
      end
      B_RESP: begin
        wrfin  = 1'b1;
        BVALID = 1'b1;
        BID    = id_r;
        if (BREADY) begin
          state_s = IDLE;
        end else begin
          state_s = B_RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_epu_in_axi_slave.sv
module tb_epu_in_axi_slave;

  logic        clk, rstn, enb_i;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA, addr, wdata, rdata_i;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        arhns, awhns, whns, rlast, wrfin, CS, OE, rvalid_i;
  logic [31:0] addr_q;

  int n_cmp = 0;
  int n_err = 0;

  epu_in_axi_slave dut (
    .clk(clk), .rstn(rstn), .enb_i(enb_i),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .arhns(arhns), .awhns(awhns), .whns(whns), .rlast(rlast), .wrfin(wrfin),
    .CS(CS), .OE(OE), .addr(addr), .wdata(wdata), .rdata_i(rdata_i), .rvalid_i(rvalid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer content is a fixed function of the byte address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // SRAM model: data for the address presented one cycle earlier.
  always @(posedge clk) addr_q <= addr;
  assign rdata_i  = mem_fn(addr_q);
  assign rvalid_i = RVALID;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    logic [12:0] flags;
    flags = {ARREADY, AWREADY, WREADY, BVALID, RVALID, RLAST, arhns, awhns, whns, rlast, wrfin, CS, OE};
    n_cmp++;
    if (flags !== 13'd0) begin n_err++; $display("FAIL %s_flags got %b exp 0", tag, flags); end
    n_cmp++;
    if (addr !== 32'd0 || wdata !== 32'd0) begin n_err++; $display("FAIL %s_addr_wdata got %h/%h exp 0/0", tag, addr, wdata); end
    n_cmp++;
    if (RDATA !== 32'd0 || RID !== 8'd0 || BID !== 8'd0) begin n_err++; $display("FAIL %s_data_ids got %h/%h/%h exp 0", tag, RDATA, RID, BID); end
  endtask

  // Full read burst with optional random backpressure and a fixed stall at one beat.
  task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [1:0] bt,
                         input logic [7:0] id, input int stall_pct, input int stall_beat, input int stall_len);
    logic [31:0] exp_a[$];
    int beat, cyc, stall_left;
    logic rr;
    for (int k = 0; k <= int'(len) + 1; k++) exp_a.push_back((bt == 2'b00) ? a : a + 32'(4 * k));
    ARVALID = 1'b1; ARADDR = a; ARLEN = len; ARBURST = bt; ARID = id; RREADY = 1'b0;
    #1;
    n_cmp++;
    if ({ARREADY, AWREADY, arhns, CS} !== 4'b1011) begin n_err++; $display("FAIL ar_phase got ARREADY/AWREADY/arhns/CS=%b exp 1011", {ARREADY, AWREADY, arhns, CS}); end
    n_cmp++;
    if (addr !== a) begin n_err++; $display("FAIL ar_addr got %h exp %h", addr, a); end
    tick();
    ARVALID = 1'b0;
    beat = 0; cyc = 0; stall_left = stall_len;
    while (beat <= int'(len) && cyc < 200) begin
      if (beat == stall_beat && stall_left > 0) begin rr = 1'b0; stall_left--; end
      else rr = ($urandom_range(99) >= stall_pct);
      RREADY = rr;
      #1;
      n_cmp++;
      if (RVALID !== 1'b1 || OE !== 1'b1 || ARREADY !== 1'b0 || AWREADY !== 1'b0 || RRESP !== 2'b00)
        begin n_err++; $display("FAIL r_ctrl beat %0d got RVALID/OE/ARREADY/AWREADY/RRESP=%b%b%b%b%b", beat, RVALID, OE, ARREADY, AWREADY, RRESP); end
      n_cmp++;
      if (RDATA !== mem_fn(exp_a[beat]) || RID !== id)
        begin n_err++; $display("FAIL r_data beat %0d got %h/%h exp %h/%h", beat, RDATA, RID, mem_fn(exp_a[beat]), id); end
      n_cmp++;
      if (RLAST !== (beat == int'(len)) || rlast !== (rr && beat == int'(len)))
        begin n_err++; $display("FAIL r_last beat %0d got RLAST/rlast=%b%b", beat, RLAST, rlast); end
      n_cmp++;
      if (addr !== (rr ? exp_a[beat+1] : exp_a[beat]))
        begin n_err++; $display("FAIL r_addr beat %0d got %h exp %h", beat, addr, rr ? exp_a[beat+1] : exp_a[beat]); end
      if (rr) beat++;
      cyc++;
      tick();
    end
    RREADY = 1'b0;
    n_cmp++;
    if (cyc >= 200) begin n_err++; $display("FAIL r_timeout got %0d beats exp %0d", beat, int'(len) + 1); end
    #1;
    n_cmp++;
    if (RVALID !== 1'b0) begin n_err++; $display("FAIL r_idle got RVALID=%b exp 0", RVALID); end
  endtask

  // Full write burst; wlast_beat > len means WLAST is never raised in time.
  task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [1:0] bt,
                          input logic [7:0] id, input int wlast_beat, input int gap_pct,
                          input int gap_len, input int bready_delay);
    int n_beats, beat, cyc, gap_left;
    logic wv;
    logic [31:0] exp_addr;
    n_beats  = (wlast_beat < int'(len) + 1) ? wlast_beat + 1 : int'(len) + 1;
    ARVALID = 1'b0; AWVALID = 1'b1; AWADDR = a; AWLEN = len; AWBURST = bt; AWID = id;
    #1;
    n_cmp++;
    if ({AWREADY, awhns, arhns} !== 3'b110) begin n_err++; $display("FAIL aw_phase got AWREADY/awhns/arhns=%b exp 110", {AWREADY, awhns, arhns}); end
    tick();
    AWVALID = 1'b0;
    beat = 0; cyc = 0; gap_left = gap_len;
    while (beat < n_beats && cyc < 200) begin
      if (beat == 1 && gap_left > 0) begin wv = 1'b0; gap_left--; end
      else wv = ($urandom_range(99) >= gap_pct);
      WVALID = wv; WDATA = $urandom; WLAST = wv && (beat == wlast_beat);
      exp_addr = (bt == 2'b00) ? a : a + 32'(4 * beat);
      #1;
      n_cmp++;
      if ({WREADY, CS, OE, BVALID, AWREADY, whns} !== {4'b1100, 1'b0, wv})
        begin n_err++; $display("FAIL w_ctrl beat %0d got WREADY/CS/OE/BVALID/AWREADY/whns=%b exp %b", beat, {WREADY, CS, OE, BVALID, AWREADY, whns}, {5'b11000, wv}); end
      n_cmp++;
      if (addr !== exp_addr || wdata !== WDATA)
        begin n_err++; $display("FAIL w_addr_data beat %0d got %h/%h exp %h/%h", beat, addr, wdata, exp_addr, WDATA); end
      if (wv) beat++;
      cyc++;
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    n_cmp++;
    if (cyc >= 200) begin n_err++; $display("FAIL w_timeout got %0d beats exp %0d", beat, n_beats); end
    for (int d = 0; d <= bready_delay; d++) begin
      BREADY = (d == bready_delay);
      #1;
      n_cmp++;
      if ({BVALID, wrfin, CS, WREADY, AWREADY} !== 5'b11000 || BID !== id || BRESP !== 2'b00)
        begin n_err++; $display("FAIL b_resp got BVALID/wrfin/CS/WREADY/AWREADY=%b BID=%h BRESP=%b exp 11000/%h/00", {BVALID, wrfin, CS, WREADY, AWREADY}, BID, BRESP, id); end
      tick();
    end
    BREADY = 1'b0;
    #1;
    n_cmp++;
    if (BVALID !== 1'b0) begin n_err++; $display("FAIL b_idle got BVALID=%b exp 0", BVALID); end
  endtask

  task automatic test_reset();
    rstn = 1'b0; enb_i = 1'b1; ARVALID = 1'b1; AWVALID = 1'b1;
    #1;
    check_all_zero("reset");
    tick();
    ARVALID = 1'b0; AWVALID = 1'b0;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_read_incr();
    do_read(32'h0000_0100, 4'd3, 2'b01, 8'h11, 0, -1, 0);
    tick();
  endtask

  task automatic test_read_backpressure();
    do_read(32'h0000_0100, 4'd3, 2'b01, 8'h22, 0, 2, 3);
    tick();
  endtask

  task automatic test_write_gap();
    do_write(32'h0000_0200, 4'd1, 2'b01, 8'h05, 1, 0, 2, 1);
    tick();
  endtask

  task automatic test_priority();
    AWVALID = 1'b1; AWADDR = 32'h0000_0300; AWLEN = 4'd0; AWBURST = 2'b01; AWID = 8'h33;
    do_read(32'h0000_0400, 4'd1, 2'b01, 8'h44, 0, -1, 0);
    do_write(32'h0000_0300, 4'd0, 2'b01, 8'h33, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_enable();
    enb_i = 1'b0; ARVALID = 1'b1; ARADDR = 32'h0000_0500; ARLEN = 4'd0; ARBURST = 2'b01; ARID = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({ARREADY, AWREADY, arhns, CS} !== 4'b0000) begin n_err++; $display("FAIL enb_low cyc %0d got %b exp 0000", i, {ARREADY, AWREADY, arhns, CS}); end
      tick();
    end
    enb_i = 1'b1;
    do_read(32'h0000_0500, 4'd0, 2'b01, 8'h55, 0, -1, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    AWVALID = 1'b1; AWADDR = 32'h0000_0600; AWLEN = 4'd3; AWBURST = 2'b01; AWID = 8'h66;
    tick();
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'hDEAD_0001; WLAST = 1'b0;
    tick();
    WDATA = 32'hDEAD_0002; rstn = 1'b0;
    #1;
    check_all_zero("reset_mid");
    tick();
    WVALID = 1'b0; rstn = 1'b1;
    tick();
    do_read(32'h0000_0700, 4'd2, 2'b01, 8'h77, 20, -1, 0);
    tick();
  endtask

  task automatic test_fixed_and_wrap();
    do_read(32'h0000_0800, 4'd2, 2'b00, 8'h88, 0, -1, 0);
    tick();
    do_read(32'hFFFF_FFF8, 4'd3, 2'b01, 8'h99, 0, -1, 0);
    tick();
    do_read(32'h0000_0900, 4'd2, 2'b10, 8'h9A, 0, -1, 0);
    tick();
    do_write(32'h0000_0A00, 4'd2, 2'b00, 8'hAA, 2, 0, 0, 0);
    tick();
  endtask

  task automatic test_wlast_early_late();
    do_write(32'h0000_0B00, 4'd5, 2'b01, 8'hBB, 2, 20, 0, 2);
    tick();
    do_write(32'h0000_0C00, 4'd2, 2'b01, 8'hCC, 9, 20, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1) == 0)
        do_read($urandom & 32'hFFFF_FFFC, 4'($urandom_range(15)), 2'($urandom_range(3)),
                8'($urandom), 30, -1, 0);
      else
        do_write($urandom & 32'hFFFF_FFFC, 4'($urandom_range(15)), 2'($urandom_range(3)),
                 8'($urandom), $urandom_range(17), 30, 0, $urandom_range(3));
      tick();
    end
  endtask

  initial begin
    rstn = 1'b0; enb_i = 1'b1;
    AWID = 8'd0; AWADDR = 32'd0; AWLEN = 4'd0; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = 32'd0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = 8'd0; ARADDR = 32'd0; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_incr();
    test_read_backpressure();
    test_write_gap();
    test_priority();
    test_enable();
    test_reset_mid();
    test_fixed_and_wrap();
    test_wlast_early_late();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
